// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge data-memory bus between the MEM-stage access
// controller (master) and a variable-latency data memory (slave).
//   busReq/busWe/busAddr/busByteEn/busWData : master -> memory
//   busAck/busRData                         : memory -> master
interface mem_access_ctrl_if #(
   parameter int WORD_BITWIDTH = 32
);
   logic                     busReq;
   logic                     busWe;
   logic [WORD_BITWIDTH-1:0] busAddr;
   logic [3:0]               busByteEn;
   logic [WORD_BITWIDTH-1:0] busWData;
   logic                     busAck;
   logic [WORD_BITWIDTH-1:0] busRData;

   modport master (
      output busReq,
      output busWe,
      output busAddr,
      output busByteEn,
      output busWData,
      input  busAck,
      input  busRData
   );

   modport slave (
      input  busReq,
      input  busWe,
      input  busAddr,
      input  busByteEn,
      input  busWData,
      output busAck,
      output busRData
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: captures one access, runs it on the
// req/ack bus, extends load data and stalls the core until completion.
// Ports: clk, rstN (sync, active low); memRead/memWrite/funct3/ALUresult/
//   regReadData2 from MEM stage; bus (master modport); stall, loadData,
//   done, fault to the core.
// Option: define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mem_access_ctrl #(
   parameter int WORD_BITWIDTH    = 32,
   parameter int TIMEOUT_CYCLES   = 255,
   parameter int TIMEOUT_BITWIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     memRead,
   input  logic                     memWrite,
   input  logic [2:0]               funct3,
   input  logic [WORD_BITWIDTH-1:0] ALUresult,
   input  logic [WORD_BITWIDTH-1:0] regReadData2,
   mem_access_ctrl_if.master        bus,
   output logic                     stall,
   output logic [WORD_BITWIDTH-1:0] loadData,
   output logic                     done,
   output logic                     fault
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_e;

   localparam logic [TIMEOUT_BITWIDTH-1:0] CNT_LAST =
      TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);

   state_e                      state_q, state_d;
   logic                        req_q, req_d;
   logic                        we_q, we_d;
   logic [WORD_BITWIDTH-1:0]    addr_q, addr_d;
   logic [3:0]                  be_q, be_d;
   logic [WORD_BITWIDTH-1:0]    wdata_q, wdata_d;
   logic [WORD_BITWIDTH-1:0]    load_q, load_d;
   logic                        done_q, done_d;
   logic                        fault_q, fault_d;
   logic [TIMEOUT_BITWIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]                  f3_q, f3_d;
   logic [1:0]                  off_q, off_d;

   logic                        any_req;
   logic                        load_ok;
   logic                        store_ok;
   logic                        misalign;
   logic                        req_err;
   logic [1:0]                  off_in;
   logic [3:0]                  be_calc;
   logic [WORD_BITWIDTH-1:0]    wdata_calc;
   logic [7:0]                  lane_b;
   logic [15:0]                 lane_h;
   logic [WORD_BITWIDTH-1:0]    ext;

   assign any_req = memRead | memWrite;
   assign off_in  = ALUresult[1:0];

   // Legal loads: 000,001,010,100,101. Legal stores: 000,001,010.
   assign load_ok  = (funct3 != 3'b011) & (funct3[2:1] != 2'b11);
   assign store_ok = ~funct3[2] & (funct3[1:0] != 2'b11);

`ifdef MISALIGN_TRAP_EN
   assign misalign = ((funct3[1:0] == 2'b01) & off_in[0])
                   | ((funct3[1:0] == 2'b10) & (off_in != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_err = (memRead & memWrite)
                  | (memRead & ~load_ok)
                  | (memWrite & ~store_ok)
                  | misalign;

   // Lane selection ignores address bits below the access size.
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = regReadData2;
      case (funct3[1:0])
         2'b00: begin
            case (off_in)
               2'b00:   be_calc = 4'b0001;
               2'b01:   be_calc = 4'b0010;
               2'b10:   be_calc = 4'b0100;
               default: be_calc = 4'b1000;
            endcase
            wdata_calc = {4{regReadData2[7:0]}};
         end
         2'b01: begin
            be_calc    = off_in[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{regReadData2[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = regReadData2;
         end
      endcase
   end

   always_comb begin
      case (off_q)
         2'b00:   lane_b = bus.busRData[7:0];
         2'b01:   lane_b = bus.busRData[15:8];
         2'b10:   lane_b = bus.busRData[23:16];
         default: lane_b = bus.busRData[31:24];
      endcase
      lane_h = off_q[1] ? bus.busRData[31:16] : bus.busRData[15:0];
      case (f3_q)
         3'b000:  ext = {{24{lane_b[7]}}, lane_b};
         3'b100:  ext = {24'b0, lane_b};
         3'b001:  ext = {{16{lane_h[15]}}, lane_h};
         3'b101:  ext = {16'b0, lane_h};
         default: ext = bus.busRData;
      endcase
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      load_d  = load_q;
      done_d  = 1'b0;
      fault_d = 1'b0;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      off_d   = off_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_req) begin
               f3_d  = funct3;
               off_d = off_in;
               cnt_d = '0;
               if (req_err) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  fault_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  we_d    = memWrite;
                  addr_d  = {ALUresult[WORD_BITWIDTH-1:2], 2'b00};
                  be_d    = be_calc;
                  wdata_d = wdata_calc;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + TIMEOUT_BITWIDTH'(1);
            if (bus.busAck) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
               if (!we_q) begin
                  load_d = ext;
               end
            end else if (cnt_q == CNT_LAST) begin
               // Abandon the transaction; data is left untouched.
               state_d = S_DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
               fault_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         load_q  <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
         f3_q    <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         load_q  <= load_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
      end
   end

   assign stall = ((state_q == S_IDLE) & any_req) | (state_q == S_REQ);

   assign bus.busReq    = req_q;
   assign bus.busWe     = we_q;
   assign bus.busAddr   = addr_q;
   assign bus.busByteEn = be_q;
   assign bus.busWData  = wdata_q;
   assign loadData      = load_q;
   assign done          = done_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed cases then random
// accesses, checked against a byte-level reference model.
module tb_mem_access_ctrl;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          req_len;
   } bus_t;

   typedef struct {
      logic        fault;
      logic [31:0] load;
      int          cyc;
   } done_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        memRead;
   logic        memWrite;
   logic [2:0]  funct3;
   logic [31:0] ALUresult;
   logic [31:0] regReadData2;
   logic        stall;
   logic [31:0] loadData;
   logic        done;
   logic        fault;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          ack_n_v = 1;
   logic [31:0] rdata_v = '0;
   bit          force_ack = 0;
   logic [31:0] model_load = '0;

   bus_t        exp_bus_q[$];
   done_t       exp_done_q[$];

   mem_access_ctrl_if #(.WORD_BITWIDTH(32)) bus_if ();

   mem_access_ctrl #(
      .WORD_BITWIDTH   (32),
      .TIMEOUT_CYCLES  (255),
      .TIMEOUT_BITWIDTH(8)
   ) dut (
      .clk         (clk),
      .rstN        (rstN),
      .memRead     (memRead),
      .memWrite    (memWrite),
      .funct3      (funct3),
      .ALUresult   (ALUresult),
      .regReadData2(regReadData2),
      .bus         (bus_if),
      .stall       (stall),
      .loadData    (loadData),
      .done        (done),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory model: acks on the ack_n_v-th cycle of busReq (0 = never).
   initial begin
      int rc = 0;
      bus_if.busAck   = 1'b0;
      bus_if.busRData = '0;
      forever begin
         @(posedge clk);
         #1;
         if (force_ack) begin
            force_ack       = 0;
            bus_if.busAck   = 1'b1;
            bus_if.busRData = 32'hFFFF_FFFF;
         end else if (bus_if.busReq) begin
            rc++;
            if (ack_n_v != 0 && rc == ack_n_v) begin
               bus_if.busAck   = 1'b1;
               bus_if.busRData = rdata_v;
            end else begin
               bus_if.busAck   = 1'b0;
               bus_if.busRData = $urandom;
            end
         end else begin
            rc              = 0;
            bus_if.busAck   = 1'b0;
            bus_if.busRData = $urandom;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT shows a bus
   // request or a completion.
   initial begin
      bit    in_req = 0;
      int    len = 0;
      bus_t  cur;
      bus_t  b;
      done_t d;
      forever begin
         @(negedge clk);
         if (!rstN) begin
            in_req = 0;
         end else begin
            chk("stall", {31'b0, stall},
                {31'b0, bus_if.busReq | ((memRead | memWrite) & ~done)});
            if (bus_if.busReq && !in_req) begin
               in_req = 1;
               len    = 1;
               if (exp_bus_q.size() == 0) begin
                  chk("unexpected_req", 32'd1, 32'd0);
               end else begin
                  b   = exp_bus_q.pop_front();
                  cur = b;
                  chk("busWe", {31'b0, bus_if.busWe}, {31'b0, b.we});
                  chk("busAddr", bus_if.busAddr, b.addr);
                  chk("busByteEn", {28'b0, bus_if.busByteEn}, {28'b0, b.be});
                  if (b.we) chk("busWData", bus_if.busWData, b.wdata);
               end
            end else if (bus_if.busReq) begin
               len++;
            end else if (in_req) begin
               in_req = 0;
               chk("req_len", len, cur.req_len);
            end
            if (done) begin
               if (exp_done_q.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  d = exp_done_q.pop_front();
                  chk("fault", {31'b0, fault}, {31'b0, d.fault});
                  chk("loadData", loadData, d.load);
                  chk("done_cyc", cyc, d.cyc);
               end
            end else if (fault) begin
               chk("fault_wo_done", {31'b0, fault}, 32'd0);
            end
         end
      end
   end

   task automatic idle(input int n);
      memRead  = 1'b0;
      memWrite = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue one access, push its expected outcome, wait for done.
   task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int ackn);
      bus_t        b;
      done_t       d;
      int          nb;
      int          off;
      int          acc;
      int          k;
      int          rl;
      bit          err;
      logic [63:0] v;
      logic [63:0] mask;
      acc = (done === 1'b1) ? cyc + 1 : cyc;
      memRead      = rd;
      memWrite     = wr;
      funct3       = f3;
      ALUresult    = addr;
      regReadData2 = rs2;
      ack_n_v      = ackn;
      rdata_v      = rdata;

      nb  = 1 << f3[1:0];
      err = 0;
      if (rd && wr) err = 1;
      else if (rd) err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      else err = !(f3 inside {3'd0, 3'd1, 3'd2});
`ifdef MISALIGN_TRAP_EN
      if (!err && (int'(addr[1:0]) % nb) != 0) err = 1;
`endif
      rl = (ackn == 0) ? 255 : ackn;
      d.fault = err || (ackn == 0);
      d.load  = model_load;
      if (!err) begin
         off       = int'(addr[1:0]);
         off       = off - (off % nb);
         b.we      = wr;
         b.addr    = addr & 32'hFFFF_FFFC;
         b.be      = 4'(((1 << nb) - 1) << off);
         for (int i = 0; i < 4; i++)
            b.wdata[8*i +: 8] = rs2[8*(i % nb) +: 8];
         b.req_len = rl;
         exp_bus_q.push_back(b);
         if (rd && ackn != 0) begin
            v    = 64'(rdata) >> (8 * off);
            mask = (64'd1 << (8 * nb)) - 64'd1;
            v    = v & mask;
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
            d.load = v[31:0];
         end
      end
      d.cyc = acc + (err ? 1 : rl + 1);
      model_load = d.load;
      exp_done_q.push_back(d);

      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (done !== 1'b1 && k < 400);
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL done_wait: no done within %0d cycles", k);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstN         = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      funct3       = '0;
      ALUresult    = '0;
      regReadData2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busReq", {31'b0, bus_if.busReq}, 32'd0);
      chk("rst_busWe", {31'b0, bus_if.busWe}, 32'd0);
      chk("rst_busAddr", bus_if.busAddr, 32'd0);
      chk("rst_busByteEn", {28'b0, bus_if.busByteEn}, 32'd0);
      chk("rst_busWData", bus_if.busWData, 32'd0);
      chk("rst_loadData", loadData, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      rstN = 1'b1;
      idle(1);

      do_op(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1);
      chk("lw_load", loadData, 32'hDEADBEEF);
      idle(1);
      do_op(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 5);
      chk("lb_load", loadData, 32'hFFFFFF80);
      do_op(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF, 2);
      chk("lbu_load", loadData, 32'h00000080);
      do_op(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 3);
      idle(2);
      do_op(1, 0, 3'd2, 32'h400, 32'h0, 32'h55, 0);
      chk("timeout_load", loadData, 32'h00000080);
      idle(1);
      do_op(1, 0, 3'd2, 32'h101, 32'h0, 32'hCAFEF00D, 1);
      idle(1);
      do_op(1, 1, 3'd2, 32'h10, 32'h0, 32'h1, 1);
      do_op(1, 0, 3'd3, 32'h10, 32'h0, 32'h1, 1);
      do_op(1, 0, 3'd6, 32'h10, 32'h0, 32'h1, 1);
      do_op(0, 1, 3'd4, 32'h10, 32'h0, 32'h1, 1);
      idle(1);

      // Reset while REQ is waiting; a late ack must be ignored.
      begin
         bus_t b;
         b.we = 1'b0; b.addr = 32'h300; b.be = 4'hF;
         b.wdata = '0; b.req_len = 0;
         exp_bus_q.push_back(b);
         memRead   = 1'b1;
         funct3    = 3'd2;
         ALUresult = 32'h300;
         ack_n_v   = 0;
         repeat (2) begin
            @(posedge clk);
            #1;
         end
         memRead = 1'b0;
         rstN    = 1'b0;
         @(posedge clk);
         #1;
         chk("rstmid_busReq", {31'b0, bus_if.busReq}, 32'd0);
         chk("rstmid_loadData", loadData, 32'd0);
         model_load = '0;
         exp_done_q.delete();
         exp_bus_q.delete();
         rstN      = 1'b1;
         force_ack = 1;
         repeat (4) begin
            @(posedge clk);
            #1;
            chk("rstmid_done", {31'b0, done}, 32'd0);
            chk("rstmid_req", {31'b0, bus_if.busReq}, 32'd0);
         end
      end

      for (int n = 0; n < 150; n++) begin
         int          r;
         bit          rd;
         bit          wr;
         logic [2:0]  f3;
         r  = $urandom_range(0, 9);
         rd = (r <= 5);
         wr = (r == 0) || (r >= 6);
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            if (rd && !wr) f3 = ($urandom_range(0, 1) != 0) ? 3'd4 + 3'(f3 % 2) : 3'(f3 % 3);
            if (wr && !rd) f3 = 3'(f3 % 3);
         end
         do_op(rd, wr, f3, $urandom, $urandom, $urandom,
               $urandom_range(1, 6));
         if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 2));
      end
      idle(3);
      chk("bus_q_empty", exp_bus_q.size(), 32'd0);
      chk("done_q_empty", exp_done_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencing controller between the MEM stage and a variable-latency data memory. It captures a load or store request and drives a req/ack bus with byte enables and lane-replicated store data. It extracts and sign- or zero-extends load data, and stalls the core until the access completes. It sits between the MEM-stage control/ALU outputs and the data-memory port.

Parameters:
WORD_BITWIDTH, 32, data/address width (logic assumes 32, 4 byte lanes)
TIMEOUT_CYCLES, 255, max cycles busReq may wait for busAck before fault
TIMEOUT_BITWIDTH, 8, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  clock, all state updates on rising edge
rstN  input  1  synchronous active-low reset
memRead  input  1  load request from MEM stage
memWrite  input  1  store request from MEM stage
funct3  input  3  access size/sign (RISC-V load/store funct3)
ALUresult  input  WORD_BITWIDTH  byte address
regReadData2  input  WORD_BITWIDTH  store data (rs2)
busReq  output  1  bus request, held until ack
busWe  output  1  1=write, 0=read
busAddr  output  WORD_BITWIDTH  word-aligned address ({addr[31:2],2'b00})
busByteEn  output  4  lane enables
busWData  output  WORD_BITWIDTH  lane-replicated store data
busAck  input  1  memory completion, single-cycle
busRData  input  WORD_BITWIDTH  read word, valid with busAck
stall  output  1  freeze core PC/regfile write
loadData  output  WORD_BITWIDTH  extended load result
done  output  1  one-cycle completion pulse
fault  output  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (rstN low at edge): state=IDLE; busReq, busWe, done, fault = 0; busAddr, busByteEn, busWData, loadData = 0; timeout counter = 0.
- Reset mid-access: busReq drops at that edge; a late busAck arriving in IDLE is ignored.
- States: IDLE, REQ, DONE.
- IDLE, memRead|memWrite=1:
  - Capture address, funct3, direction and store data.
  - Clear the timeout counter.
  - Go to REQ, or to DONE when an error applies (see below).
- IDLE, no request: stay in IDLE.
- REQ:
  - busReq=1, outputs stable, counter increments each cycle.
  - busAck=1 → DONE; for a read, register the extracted load into loadData.
  - Counter reaches TIMEOUT_CYCLES without ack → DONE with fault.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - Requests present in DONE are ignored; the core advances in this cycle.
- stall (combinational) = (IDLE & (memRead|memWrite)) | REQ. It is low in DONE.
- Minimum latency with ack on the first REQ cycle:
  - stall high in cycles 0 and 1.
  - done in cycle 2.
- Errors: each gives fault=1 with done, no bus transaction (or the bus transaction abandoned on timeout), loadData unchanged.
  - memRead & memWrite both high.
  - Illegal funct3: loads 011/11x; stores other than 000/001/010.
  - Timeout.
- Byte enables, off = addr[1:0]:
  - Byte access: 4'b0001<<off.
  - Half access: 4'b0011<<{off[1],1'b0}.
  - Word access: 4'b1111.
- busWData:
  - SB: {4{rs2[7:0]}}.
  - SH: {2{rs2[15:0]}}.
  - SW: rs2.
- Load extraction, selected by off:
  - LB/LBU: byte lane, sign-/zero-extended.
  - LH/LHU: half lane, sign-/zero-extended.
  - LW: full word.
- loadData holds its value until the next successful load.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]≠0 goes IDLE→DONE with fault=1. No busReq; loadData unchanged.
- Undefined: misalignment is not detected. Low address bits beyond access size are ignored (half uses addr[1] only, word uses none), and the access proceeds normally.

Test Plan:
- Reset, then LW at 0x100 with busRData=0xDEADBEEF:
  - Expect busAddr=0x100, busByteEn=1111.
  - Expect loadData=0xDEADBEEF with done in cycle 2.
  - Expect stall high in cycles 0–1.
- LB at 0x103, busRData=0x80FFFFFF, ack delayed 5 cycles:
  - Expect busReq held 5 cycles.
  - Expect loadData=0xFFFFFF80.
- LBU at 0x103 with the same data → expect loadData=0x00000080.
- SH at 0x202, rs2=0x1234ABCD:
  - Expect busWe=1, busAddr=0x200, busByteEn=1100, busWData=0xABCDABCD.
- No ack:
  - Expect fault and done after TIMEOUT_CYCLES (255), then IDLE.
  - Expect loadData unchanged.
- LW at 0x101:
  - With MISALIGN_TRAP_EN: fault in cycle 1, busReq never asserted.
  - Without it: busAddr=0x100, byteEn=1111, normal completion.
- rstN low during REQ: busReq=0 next cycle, a following busAck is ignored, done never pulses.
